// File: rtl/fwd_scoreboard_if.sv
// EX-side and back-end signal bundle for the forwarding scoreboard.
// slave = the scoreboard itself, master = whatever drives EX and the load path.
interface fwd_scoreboard_if #(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 2,
    parameter int RA_W    = 5,
    parameter int CNT_W   = 16
);
    logic                    pipe_adv;
    logic                    ex_valid;
    logic [RA_W-1:0]         ex_rd;
    logic                    ex_wr;
    logic                    ex_rdy;
    logic [XLEN-1:0]         ex_result;
    logic [NUM_SRC*RA_W-1:0] ex_src;
    logic [NUM_SRC-1:0]      ex_src_use;
    logic                    ld_resp_valid;
    logic [XLEN-1:0]         ld_resp_data;
    logic [NUM_SRC-1:0]      src_fwd;
    logic [NUM_SRC*XLEN-1:0] src_fwd_data;
    logic                    stall;
    logic                    wb_valid;
    logic [RA_W-1:0]         wb_rd;
    logic [XLEN-1:0]         wb_data;
    logic [CNT_W-1:0]        stall_cnt;
    logic                    stall_timeout;
    logic                    resp_orphan;

    modport slave (
        input  pipe_adv, ex_valid, ex_rd, ex_wr, ex_rdy, ex_result, ex_src, ex_src_use,
               ld_resp_valid, ld_resp_data,
        output src_fwd, src_fwd_data, stall, wb_valid, wb_rd, wb_data,
               stall_cnt, stall_timeout, resp_orphan
    );

    modport master (
        output pipe_adv, ex_valid, ex_rd, ex_wr, ex_rdy, ex_result, ex_src, ex_src_use,
               ld_resp_valid, ld_resp_data,
        input  src_fwd, src_fwd_data, stall, wb_valid, wb_rd, wb_data,
               stall_cnt, stall_timeout, resp_orphan
    );
endinterface

// File: rtl/fwd_scoreboard.sv
// Shift-register scoreboard of in-flight producers behind EX: operand forwarding,
// load-use stall, oldest-entry write-back, stall statistics and sticky error flags.
module fwd_scoreboard #(
    parameter int XLEN      = 32,
    parameter int NUM_SRC   = 2,
    parameter int DEPTH     = 3,
    parameter int RA_W      = 5,
    parameter int MAX_STALL = 16,
    parameter int CNT_W     = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    fwd_scoreboard_if.slave sb
);
    localparam int RUN_W = $clog2(MAX_STALL + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);
    localparam logic [RUN_W-1:0] RUN_PRE = RUN_W'(MAX_STALL - 1);

    logic [DEPTH-1:0] v_q, v_d, rdy_q, rdy_d, rdy_f, fill_sel;
    logic [RA_W-1:0]  rd_q [DEPTH];
    logic [RA_W-1:0]  rd_d [DEPTH];
    logic [XLEN-1:0]  data_q [DEPTH];
    logic [XLEN-1:0]  data_d [DEPTH];
    logic [XLEN-1:0]  data_f [DEPTH];
    logic             fill_hit;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             timeout_q, timeout_d, orphan_q, orphan_d;

    logic [NUM_SRC-1:0]      haz, fwd;
    logic [NUM_SRC*XLEN-1:0] fwd_data;
    logic [RA_W-1:0]         src_sel;
    logic                    found, p_rdy, p_fill;
    logic [XLEN-1:0]         p_data;
    logic                    stall, alloc, wb_valid;

    // Loads return in order, so a response always belongs to the oldest pending entry.
    always_comb begin
        fill_sel = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (v_q[k] && !rdy_q[k]) begin
                fill_sel    = '0;
                fill_sel[k] = 1'b1;
            end
        end
        fill_hit = |fill_sel;
        rdy_f    = rdy_q;
        data_f   = data_q;
        if (sb.ld_resp_valid) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (fill_sel[k]) begin
                    rdy_f[k]  = 1'b1;
                    data_f[k] = sb.ld_resp_data;
                end
            end
        end
    end

    always_comb begin
        haz      = '0;
        fwd      = '0;
        fwd_data = '0;
        src_sel  = '0;
        found    = 1'b0;
        p_rdy    = 1'b0;
        p_fill   = 1'b0;
        p_data   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_sel = sb.ex_src[i*RA_W +: RA_W];
            found   = 1'b0;
            p_rdy   = 1'b0;
            p_fill  = 1'b0;
            p_data  = '0;
            // Scan oldest to youngest so the youngest match is the one left standing.
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (v_q[k] && rd_q[k] == src_sel) begin
                    found  = 1'b1;
                    p_rdy  = rdy_q[k];
                    p_fill = fill_sel[k];
                    p_data = data_q[k];
                end
            end
            if (sb.ex_src_use[i] && src_sel != '0 && found) begin
                if (p_rdy) begin
                    fwd[i]                    = 1'b1;
                    fwd_data[i*XLEN +: XLEN]  = p_data;
                end else if (p_fill && sb.ld_resp_valid) begin
                    fwd[i]                    = 1'b1;
                    fwd_data[i*XLEN +: XLEN]  = sb.ld_resp_data;
                end else begin
                    haz[i] = 1'b1;
                end
            end
        end
    end

    assign stall    = sb.ex_valid && (|haz);
    assign alloc    = sb.ex_valid && sb.ex_wr && !stall && (sb.ex_rd != '0);
    assign wb_valid = sb.pipe_adv && v_q[DEPTH-1] && rdy_f[DEPTH-1];

    always_comb begin
        v_d    = v_q;
        rdy_d  = rdy_f;
        rd_d   = rd_q;
        data_d = data_f;
        if (sb.pipe_adv) begin
            for (int k = 1; k < DEPTH; k++) begin
                v_d[k]    = v_q[k-1];
                rdy_d[k]  = rdy_f[k-1];
                rd_d[k]   = rd_q[k-1];
                data_d[k] = data_f[k-1];
            end
            v_d[0]    = alloc;
            rdy_d[0]  = sb.ex_rdy;
            rd_d[0]   = sb.ex_rd;
            data_d[0] = sb.ex_result;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        run_d       = '0;
        if (stall) begin
            if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
            run_d = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
        end
        timeout_d = timeout_q || (stall && run_q >= RUN_PRE);
        // A pending oldest entry pushed out without its data is lost as well.
        orphan_d  = orphan_q || (sb.ld_resp_valid && !fill_hit)
                  || (sb.pipe_adv && v_q[DEPTH-1] && !rdy_f[DEPTH-1]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q         <= '0;
            rdy_q       <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                rd_q[k]   <= '0;
                data_q[k] <= '0;
            end
            stall_cnt_q <= '0;
            run_q       <= '0;
            timeout_q   <= 1'b0;
            orphan_q    <= 1'b0;
        end else begin
            v_q         <= v_d;
            rdy_q       <= rdy_d;
            rd_q        <= rd_d;
            data_q      <= data_d;
            stall_cnt_q <= stall_cnt_d;
            run_q       <= run_d;
            timeout_q   <= timeout_d;
            orphan_q    <= orphan_d;
        end
    end

    assign sb.src_fwd       = fwd;
    assign sb.src_fwd_data  = fwd_data;
    assign sb.stall         = stall;
    assign sb.wb_valid      = wb_valid;
    assign sb.wb_rd         = wb_valid ? rd_q[DEPTH-1] : '0;
    assign sb.wb_data       = wb_valid ? data_f[DEPTH-1] : '0;
    assign sb.stall_cnt     = stall_cnt_q;
    assign sb.stall_timeout = timeout_q;
    assign sb.resp_orphan   = orphan_q;
endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: forwarding, load-use stall, retire, timeout, orphan.
module tb_fwd_scoreboard;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    fwd_scoreboard_if #(.XLEN(32), .NUM_SRC(2), .RA_W(5), .CNT_W(16)) bus ();

    fwd_scoreboard #(
        .XLEN(32), .NUM_SRC(2), .DEPTH(3), .RA_W(5), .MAX_STALL(4), .CNT_W(16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .sb   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.pipe_adv      = 1'b0;
        bus.ex_valid      = 1'b0;
        bus.ex_rd         = '0;
        bus.ex_wr         = 1'b0;
        bus.ex_rdy        = 1'b0;
        bus.ex_result     = '0;
        bus.ex_src        = '0;
        bus.ex_src_use    = '0;
        bus.ld_resp_valid = 1'b0;
        bus.ld_resp_data  = '0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic rdy, input logic [31:0] res);
        idle();
        bus.pipe_adv  = 1'b1;
        bus.ex_valid  = 1'b1;
        bus.ex_wr     = 1'b1;
        bus.ex_rd     = rd;
        bus.ex_rdy    = rdy;
        bus.ex_result = res;
    endtask

    task automatic reader(input logic [4:0] s1, input logic [4:0] s0, input logic [1:0] use_v);
        idle();
        bus.ex_valid   = 1'b1;
        bus.ex_src     = {s1, s0};
        bus.ex_src_use = use_v;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_src_fwd", 64'(bus.src_fwd), 64'd0);
        chk("rst_stall", 64'(bus.stall), 64'd0);
        chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
        chk("rst_stall_cnt", 64'(bus.stall_cnt), 64'd0);
        chk("rst_timeout", 64'(bus.stall_timeout), 64'd0);
        chk("rst_orphan", 64'(bus.resp_orphan), 64'd0);

        // ALU back-to-back
        issue(5'd5, 1'b1, 32'h11);
        tick();
        reader(5'd0, 5'd5, 2'b01);
        #1;
        chk("alu_fwd", 64'(bus.src_fwd), 64'd1);
        chk("alu_data", 64'(bus.src_fwd_data), 64'h11);
        chk("alu_stall", 64'(bus.stall), 64'd0);

        // Load-use: stall, then same-cycle bypass
        issue(5'd7, 1'b0, 32'h0);
        tick();
        reader(5'd0, 5'd7, 2'b01);
        #1;
        chk("lu_stall", 64'(bus.stall), 64'd1);
        chk("lu_nofwd", 64'(bus.src_fwd), 64'd0);
        tick();
        chk("lu_stall_cnt", 64'(bus.stall_cnt), 64'd1);
        reader(5'd0, 5'd7, 2'b01);
        bus.pipe_adv      = 1'b1;
        bus.ld_resp_valid = 1'b1;
        bus.ld_resp_data  = 32'hDEAD;
        #1;
        chk("lu_byp_fwd", 64'(bus.src_fwd), 64'd1);
        chk("lu_byp_data", 64'(bus.src_fwd_data), 64'hDEAD);
        chk("lu_byp_stall", 64'(bus.stall), 64'd0);
        tick();
        chk("lu_cnt_hold", 64'(bus.stall_cnt), 64'd1);

        // Youngest wins; the two older entries retire as x3 is issued twice
        issue(5'd3, 1'b1, 32'hA);
        #1;
        chk("ret_x5_valid", 64'(bus.wb_valid), 64'd1);
        chk("ret_x5_rd", 64'(bus.wb_rd), 64'd5);
        chk("ret_x5_data", 64'(bus.wb_data), 64'h11);
        tick();
        issue(5'd3, 1'b1, 32'hB);
        #1;
        chk("ret_x7_data", 64'(bus.wb_data), 64'hDEAD);
        tick();
        reader(5'd3, 5'd3, 2'b11);
        #1;
        chk("yw_fwd", 64'(bus.src_fwd), 64'd3);
        chk("yw_data", 64'(bus.src_fwd_data), {32'hB, 32'hB});
        chk("yw_stall", 64'(bus.stall), 64'd0);

        // x0 producer is not allocated; x0 and unused sources never forward
        issue(5'd0, 1'b1, 32'h99);
        tick();
        reader(5'd3, 5'd0, 2'b01);
        #1;
        chk("x0_fwd", 64'(bus.src_fwd), 64'd0);
        chk("x0_data", 64'(bus.src_fwd_data), 64'd0);
        chk("x0_stall", 64'(bus.stall), 64'd0);
        idle();
        bus.pipe_adv = 1'b1;
        #1;
        chk("ret_x3a_data", 64'(bus.wb_data), 64'hA);
        tick();
        #1;
        chk("ret_x3b_data", 64'(bus.wb_data), 64'hB);
        tick();
        #1;
        chk("x0_no_wb", 64'(bus.wb_valid), 64'd0);
        tick();

        // Orphan response
        idle();
        bus.ld_resp_valid = 1'b1;
        bus.ld_resp_data  = 32'h1234;
        #1;
        chk("orphan_pre", 64'(bus.resp_orphan), 64'd0);
        tick();
        idle();
        chk("orphan_set", 64'(bus.resp_orphan), 64'd1);

        // Retire x9 three advances after issue
        issue(5'd9, 1'b1, 32'h5);
        tick();
        idle();
        bus.pipe_adv = 1'b1;
        tick();
        tick();
        bus.pipe_adv = 1'b0;
        #1;
        chk("x9_hold_nowb", 64'(bus.wb_valid), 64'd0);
        bus.pipe_adv = 1'b1;
        #1;
        chk("x9_wb_valid", 64'(bus.wb_valid), 64'd1);
        chk("x9_wb_rd", 64'(bus.wb_rd), 64'd9);
        chk("x9_wb_data", 64'(bus.wb_data), 64'h5);
        tick();

        // Timeout with MAX_STALL=4
        issue(5'd8, 1'b0, 32'h0);
        tick();
        reader(5'd0, 5'd8, 2'b01);
        tick();
        tick();
        tick();
        chk("to_after3", 64'(bus.stall_timeout), 64'd0);
        tick();
        chk("to_after4", 64'(bus.stall_timeout), 64'd1);
        chk("to_stall_cnt", 64'(bus.stall_cnt), 64'd5);
        idle();
        tick();
        chk("to_sticky", 64'(bus.stall_timeout), 64'd1);
        chk("to_cnt_hold", 64'(bus.stall_cnt), 64'd5);

        // Reset mid-operation
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst2_timeout", 64'(bus.stall_timeout), 64'd0);
        chk("rst2_stall_cnt", 64'(bus.stall_cnt), 64'd0);
        chk("rst2_orphan", 64'(bus.resp_orphan), 64'd0);
        reader(5'd0, 5'd8, 2'b01);
        bus.pipe_adv = 1'b1;
        #1;
        chk("rst2_stall", 64'(bus.stall), 64'd0);
        chk("rst2_fwd", 64'(bus.src_fwd), 64'd0);
        chk("rst2_wb", 64'(bus.wb_valid), 64'd0);
        tick();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
